// File: rtl/vga_pkg.sv
// Shared timing defaults, pixel-format codes and sync polarity codes for the VGA output path.
// Also provides the 16-bit to 24-bit pixel expansion used by the stream drivers.
package vga_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam int FMT_RGB565 = 0;
   localparam int FMT_GR88   = 1;

   localparam int SYNC_ACTIVE_LOW  = 0;
   localparam int SYNC_ACTIVE_HIGH = 1;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   // RGB565 widens each channel by replicating its MSBs; GR88 has no blue channel.
   function automatic rgb888_t map_pixel(input logic [15:0] d, input logic gr88);
      rgb888_t p;
      if (gr88) begin
         p.r = d[7:0];
         p.g = d[15:8];
         p.b = 8'h00;
      end else begin
         p.r = {d[15:11], d[15:13]};
         p.g = {d[10:5], d[10:9]};
         p.b = {d[4:0], d[4:2]};
      end
      return p;
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Parametrised raster counters producing display-enable, raw (active-true) syncs and frame start.
// Holds at (0,0) for one clock after reset so nothing is requested while reset is asserted.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic clk,
   input  logic rst,
   output logic o_de,
   output logic o_hs,
   output logic o_vs,
   output logic o_frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);

   localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);

   logic           r_run;
   logic [H_W-1:0] r_h_cnt;
   logic [V_W-1:0] r_v_cnt;

   // Raster position; the first edge after reset only arms r_run, leaving (0,0) visible for one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run   <= 1'b0;
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (!r_run) begin
         r_run <= 1'b1;
      end else if (r_h_cnt == H_LAST) begin
         r_h_cnt <= '0;
         if (r_v_cnt == V_LAST) begin
            r_v_cnt <= '0;
         end else begin
            r_v_cnt <= r_v_cnt + 1'b1;
         end
      end else begin
         r_h_cnt <= r_h_cnt + 1'b1;
      end
   end

   // Region decode from the registered position.
   always_comb begin
      o_de          = r_run & (r_h_cnt < H_ACT_END) & (r_v_cnt < V_ACT_END);
      o_hs          = r_run & (r_h_cnt >= H_SYNC_BEG) & (r_h_cnt < H_SYNC_END);
      o_vs          = r_run & (r_v_cnt >= V_SYNC_BEG) & (r_v_cnt < V_SYNC_END);
      o_frame_start = r_run & (r_h_cnt == '0) & (r_v_cnt == '0);
   end

endmodule

// File: rtl/vga_stream_driver.sv
// VGA output stage: pulls pixels from a 1-cycle-latency FIFO, expands them to 24-bit colour,
// aligns sync/blank with the data (2-clock latency) and tracks FIFO underflow.
module vga_stream_driver
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int SYNC_POL = SYNC_ACTIVE_LOW,
   parameter int PIX_FMT  = FMT_RGB565
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] fifo_rddata,
   input  logic        fifo_empty,
   output logic        fifo_rdreq,
   output logic        oHS,
   output logic        oVS,
   output logic        oBLANK_n,
   output logic [7:0]  r_data,
   output logic [7:0]  g_data,
   output logic [7:0]  b_data,
   output logic        frame_start,
   output logic        underflow,
   output logic [15:0] underflow_cnt
);

   localparam logic SYNC_ON = 1'(SYNC_POL);
   localparam logic IS_GR88 = (PIX_FMT == FMT_GR88);

   logic    w_de0;
   logic    w_hs0;
   logic    w_vs0;
   logic    r_de1;
   logic    r_ok1;
   logic    r_hs1;
   logic    r_vs1;
   rgb888_t w_pix;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk           (clk),
      .rst           (rst),
      .o_de          (w_de0),
      .o_hs          (w_hs0),
      .o_vs          (w_vs0),
      .o_frame_start (frame_start)
   );

   assign fifo_rdreq = w_de0 & ~fifo_empty;

   // Pixel colour for stage 2: black whenever no word was actually read for this position.
   always_comb begin
      if (r_de1 && r_ok1) begin
         w_pix = map_pixel(fifo_rddata, IS_GR88);
      end else begin
         w_pix = '0;
      end
   end

   // Stage 1: remember what stage 0 decided while the FIFO word is in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_de1 <= 1'b0;
         r_ok1 <= 1'b0;
         r_hs1 <= 1'b0;
         r_vs1 <= 1'b0;
      end else begin
         r_de1 <= w_de0;
         r_ok1 <= fifo_rdreq;
         r_hs1 <= w_hs0;
         r_vs1 <= w_vs0;
      end
   end

   // Stage 2: pin registers, plus underflow accounting for visible pixels that had no data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oHS           <= ~SYNC_ON;
         oVS           <= ~SYNC_ON;
         oBLANK_n      <= 1'b0;
         r_data        <= 8'h00;
         g_data        <= 8'h00;
         b_data        <= 8'h00;
         underflow     <= 1'b0;
         underflow_cnt <= 16'h0000;
      end else begin
         oHS      <= r_hs1 ? SYNC_ON : ~SYNC_ON;
         oVS      <= r_vs1 ? SYNC_ON : ~SYNC_ON;
         oBLANK_n <= r_de1;
         r_data   <= w_pix.r;
         g_data   <= w_pix.g;
         b_data   <= w_pix.b;
         if (r_de1 && !r_ok1) begin
            underflow <= 1'b1;
            if (underflow_cnt != 16'hFFFF) begin
               underflow_cnt <= underflow_cnt + 16'd1;
            end else begin
               underflow_cnt <= underflow_cnt;
            end
         end else begin
            underflow     <= underflow;
            underflow_cnt <= underflow_cnt;
         end
      end
   end

endmodule

// File: tb/tb_vga_stream_driver.sv
// Bench: default-timing RGB565 instance (latency, hsync, underflow on line 3) and a small
// GR88 active-high-sync instance (full-frame timing, read count, mid-line reset).
module tb_vga_stream_driver;

   typedef struct {
      logic [15:0] w;
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
   } vec_t;

   vec_t tbl_a [8];
   vec_t tbl_b [2];

   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   logic [15:0] rddata_a = 16'h0000;
   logic [15:0] rddata_b = 16'h0000;
   logic        empty_a, empty_b;
   logic        rdreq_a, hs_a, vs_a, blank_a, fs_a, uf_a;
   logic        rdreq_b, hs_b, vs_b, blank_b, fs_b, uf_b;
   logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
   logic [15:0] ufc_a, ufc_b;

   int n_cmp = 0;
   int n_bad = 0;
   int nA, nB, kA, hA, vA, pA, kB, hB0, vB0, pB, h, v, f, idx;
   int a_rd_idx = 0;
   int b_rd_idx = 0;
   int rd_frame_b, fs_cnt_b, fs_second_b, hold;
   bit b_restarted;
   logic [7:0]  er, eg, eb;
   logic [15:0] wd;

   always #5 clk = ~clk;

   vga_stream_driver u_dut_a (
      .clk(clk), .rst(rst_a), .fifo_rddata(rddata_a), .fifo_empty(empty_a),
      .fifo_rdreq(rdreq_a), .oHS(hs_a), .oVS(vs_a), .oBLANK_n(blank_a),
      .r_data(r_a), .g_data(g_a), .b_data(b_a), .frame_start(fs_a),
      .underflow(uf_a), .underflow_cnt(ufc_a)
   );

   vga_stream_driver #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1), .PIX_FMT(1)
   ) u_dut_b (
      .clk(clk), .rst(rst_b), .fifo_rddata(rddata_b), .fifo_empty(empty_b),
      .fifo_rdreq(rdreq_b), .oHS(hs_b), .oVS(vs_b), .oBLANK_n(blank_b),
      .r_data(r_b), .g_data(g_b), .b_data(b_b), .frame_start(fs_b),
      .underflow(uf_b), .underflow_cnt(ufc_b)
   );

   function automatic logic [15:0] word_a(input int i);
      if (i < 8) return tbl_a[i].w;
      return 16'(i);
   endfunction

   function automatic logic [15:0] word_b(input int i);
      logic [7:0] lo;
      if (i < 2) return tbl_b[i].w;
      lo = 8'(i);
      return {lo, lo + 8'h40};
   endfunction

   function automatic logic [23:0] exp565(input logic [15:0] w);
      return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
   endfunction

   // 1-cycle-latency FIFO models: word appears the cycle after the request.
   always @(posedge clk) begin
      if (rdreq_a) begin
         rddata_a <= word_a(a_rd_idx);
         a_rd_idx <= a_rd_idx + 1;
      end
   end

   always @(posedge clk) begin
      if (rst_b) begin
         b_rd_idx <= 0;
      end else if (rdreq_b) begin
         rddata_b <= word_b(b_rd_idx);
         b_rd_idx <= b_rd_idx + 1;
      end
   end

   task automatic chk(input string nm, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (nA=%0d nB=%0d)", nm, act, exp_v, nA, nB);
      end
   endtask

   initial begin
      tbl_a[0] = '{16'hF800, 8'hFF, 8'h00, 8'h00};
      tbl_a[1] = '{16'h07E0, 8'h00, 8'hFF, 8'h00};
      tbl_a[2] = '{16'h001F, 8'h00, 8'h00, 8'hFF};
      tbl_a[3] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF};
      tbl_a[4] = '{16'h0000, 8'h00, 8'h00, 8'h00};
      tbl_a[5] = '{16'h8410, 8'h84, 8'h82, 8'h84};
      tbl_a[6] = '{16'h1234, 8'h10, 8'h45, 8'hA5};
      tbl_a[7] = '{16'h0841, 8'h08, 8'h08, 8'h08};
      tbl_b[0] = '{16'h3C5A, 8'h5A, 8'h3C, 8'h00};
      tbl_b[1] = '{16'hA5FF, 8'hFF, 8'hA5, 8'h00};

      rst_a = 1'b1; rst_b = 1'b1; empty_a = 1'b0; empty_b = 1'b0;
      nA = 0; nB = 0; b_restarted = 1'b0; hold = 0;
      rd_frame_b = 0; fs_cnt_b = 0; fs_second_b = -1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("a_rst_rdreq", rdreq_a, 0);
      chk("a_rst_hs", hs_a, 1);
      chk("a_rst_vs", vs_a, 1);
      chk("a_rst_blank", blank_a, 0);
      chk("a_rst_rgb", {r_a, g_a, b_a}, 0);
      chk("a_rst_fstart", fs_a, 0);
      chk("a_rst_uf", {uf_a, ufc_a}, 0);
      chk("b_rst_hs", hs_b, 0);
      chk("b_rst_vs", vs_b, 0);
      chk("b_rst_rdreq", rdreq_b, 0);
      rst_a = 1'b0; rst_b = 1'b0;

      for (int cyc = 0; cyc < 2430; cyc++) begin
         @(posedge clk);
         nA++;
         if (!rst_b) nB++;
         @(negedge clk);
         kA = nA - 1; hA = kA % 800; vA = kA / 800;
         empty_a = (vA == 3 && hA >= 10 && hA <= 14);
         #1;
         // default instance: stage-0 outputs
         chk("a_rdreq", rdreq_a, (hA < 640 && !empty_a) ? 1 : 0);
         chk("a_fstart", fs_a, (kA == 0) ? 1 : 0);
         // default instance: pin outputs, two clocks behind the raster position
         if (nA >= 3) begin
            pA = nA - 3; h = pA % 800; v = pA / 800;
            chk("a_hs", hs_a, (h >= 656 && h < 752) ? 0 : 1);
            chk("a_vs", vs_a, 1);
            chk("a_blank", blank_a, (h < 640) ? 1 : 0);
            {er, eg, eb} = 24'h0;
            if (h < 640 && !(v == 3 && h >= 10 && h <= 14)) begin
               idx = v * 640 + h - ((v > 3 || (v == 3 && h > 14)) ? 5 : 0);
               if (idx < 8) {er, eg, eb} = {tbl_a[idx].r, tbl_a[idx].g, tbl_a[idx].b};
               else {er, eg, eb} = exp565(word_a(idx));
            end
            chk("a_rgb", {r_a, g_a, b_a}, {er, eg, eb});
         end else begin
            chk("a_pre_blank", blank_a, 0);
            chk("a_pre_rgb", {r_a, g_a, b_a}, 0);
         end
         if (nA == 2400) chk("a_uf_before", uf_a, 0);

         // small instance
         if (rst_b) begin
            hold++;
            if (hold == 2) begin
               rst_b = 1'b0;
               nB = 0;
            end
         end else if (nB >= 1) begin
            kB = nB - 1; hB0 = kB % 14; vB0 = (kB / 14) % 7;
            chk("b_rdreq", rdreq_b, (hB0 < 8 && vB0 < 4) ? 1 : 0);
            chk("b_fstart", fs_b, (kB % 98 == 0) ? 1 : 0);
            if (!b_restarted) begin
               if (kB < 98 && rdreq_b) rd_frame_b++;
               if (kB < 196 && fs_b) begin
                  fs_cnt_b++;
                  if (kB != 0) fs_second_b = kB;
               end
            end
            if (nB >= 3) begin
               pB = nB - 3; h = pB % 14; v = (pB / 14) % 7; f = pB / 98;
               chk("b_hs", hs_b, (h >= 10 && h < 12) ? 1 : 0);
               chk("b_vs", vs_b, (v == 5) ? 1 : 0);
               chk("b_blank", blank_b, (h < 8 && v < 4) ? 1 : 0);
               {er, eg, eb} = 24'h0;
               if (h < 8 && v < 4) begin
                  idx = f * 32 + v * 8 + h;
                  if (idx < 2) begin
                     {er, eg, eb} = {tbl_b[idx].r, tbl_b[idx].g, tbl_b[idx].b};
                  end else begin
                     wd = word_b(idx);
                     {er, eg, eb} = {wd[7:0], wd[15:8], 8'h00};
                  end
               end
               chk("b_rgb", {r_b, g_b, b_b}, {er, eg, eb});
            end else begin
               chk("b_pre_blank", blank_b, 0);
               chk("b_pre_rgb", {r_b, g_b, b_b}, 0);
            end
            if (!b_restarted && nB == 197) begin
               chk("b_reads_per_frame", rd_frame_b, 32);
               chk("b_fstart_count", fs_cnt_b, 2);
               chk("b_fstart_period", fs_second_b, 98);
            end
            if (!b_restarted && nB == 199) begin
               chk("b_pre_rst_rdreq", rdreq_b, 1);
               chk("b_pre_rst_blank", blank_b, 1);
               rst_b = 1'b1;
               #1;
               chk("b_mid_rst_rdreq", rdreq_b, 0);
               chk("b_mid_rst_blank", blank_b, 0);
               chk("b_mid_rst_sync", {hs_b, vs_b}, 0);
               chk("b_mid_rst_rgb", {r_b, g_b, b_b}, 0);
               chk("b_mid_rst_fstart", fs_b, 0);
               b_restarted = 1'b1;
            end
         end
      end

      chk("a_uf_flag", uf_a, 1);
      chk("a_uf_cnt", ufc_a, 5);
      chk("b_uf_cnt", {uf_b, ufc_b}, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
